key_sw_io: RTL

KEY_SW_IO -- requirements
Module: key_sw_io

---
 rtl/io_pkg.sv | 23 ++
 rtl/debounce_bit.sv | 73 +++++++
 rtl/key_sw_io.sv | 102 ++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared I/O address map and control-register layout for the KEY/SW peripheral
// and the data-memory address decoder.
package io_pkg;

    localparam int DBITS = 32;

    localparam logic [31:0] ADDR_KEY    = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW     = 32'hF000_0014;
    localparam logic [31:0] ADDR_KCTRL  = 32'hF000_0110;
    localparam logic [31:0] ADDR_SWCTRL = 32'hF000_0114;

    localparam int READY_BIT   = 0;
    localparam int OVERRUN_BIT = 2;

    function automatic logic [31:0] ctrl_word(input logic ready, input logic overrun);
        logic [31:0] w;
        w              = '0;
        w[READY_BIT]   = ready;
        w[OVERRUN_BIT] = overrun;
        return w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input pin: two-flop synchronizer, optional inversion, and a stable-sample
// debouncer (KEYSW_DEBOUNCE_EN); without the macro the synchronized value is used directly.
module debounce_bit #(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RST_VAL         = 1'b0,
    parameter logic INVERT          = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic db_o,
    output logic change_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef KEYSW_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync_val;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign sync_val = sync2_q ^ INVERT;

    // Counter only runs while the synchronized level disagrees with the accepted one.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_val != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync_val;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign db_o     = db_q;
    assign change_o = (db_d != db_q);
`else
    logic unused_debounce_cycles;
    assign unused_debounce_cycles = (DEBOUNCE_CYCLES < 2);

    // The accepted level is the second stage, so it changes when the stages differ.
    assign db_o     = sync2_q ^ INVERT;
    assign change_o = sync1_q ^ sync2_q;
`endif

endmodule

// File: rtl/key_sw_io.sv
// Memory-mapped KEY/SW peripheral: debounced data registers plus Ready/Overrun
// control registers. Debouncing is enabled by defining KEYSW_DEBOUNCE_EN.
module key_sw_io #(
    parameter int                DBITS           = io_pkg::DBITS,
    parameter int                DEBOUNCE_CYCLES = 500000,
    parameter logic [DBITS-1:0]  ADDR_KEY        = DBITS'(io_pkg::ADDR_KEY),
    parameter logic [DBITS-1:0]  ADDR_SW         = DBITS'(io_pkg::ADDR_SW),
    parameter logic [DBITS-1:0]  ADDR_KCTRL      = DBITS'(io_pkg::ADDR_KCTRL),
    parameter logic [DBITS-1:0]  ADDR_SWCTRL     = DBITS'(io_pkg::ADDR_SWCTRL)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       key_in,
    input  logic [9:0]       sw_in,
    input  logic [DBITS-1:0] addr,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wdata,
    output logic             hit,
    output logic [DBITS-1:0] rdata
);

    import io_pkg::*;

    logic [3:0] key_db;
    logic [3:0] key_chg;
    logic [9:0] sw_db;
    logic [9:0] sw_chg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .RST_VAL        (1'b1),
                .INVERT         (1'b1)
            ) u_db (
                .clk     (clk),
                .reset   (reset),
                .raw_i   (key_in[gi]),
                .db_o    (key_db[gi]),
                .change_o(key_chg[gi])
            );
        end
        for (gi = 0; gi < 10; gi++) begin : g_sw
            debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .RST_VAL        (1'b0),
                .INVERT         (1'b0)
            ) u_db (
                .clk     (clk),
                .reset   (reset),
                .raw_i   (sw_in[gi]),
                .db_o    (sw_db[gi]),
                .change_o(sw_chg[gi])
            );
        end
    endgenerate

    logic sel_key, sel_sw, sel_kctrl, sel_swctrl;

    assign sel_key    = (addr == ADDR_KEY);
    assign sel_sw     = (addr == ADDR_SW);
    assign sel_kctrl  = (addr == ADDR_KCTRL);
    assign sel_swctrl = (addr == ADDR_SWCTRL);
    assign hit        = sel_key | sel_sw | sel_kctrl | sel_swctrl;

    // Index 0 = KEY channel, index 1 = SW channel.
    logic [1:0] any_chg, data_rd, ovr_clr;
    logic [1:0] ready_q, ready_d, overrun_q, overrun_d;

    assign any_chg = {|sw_chg, |key_chg};
    assign data_rd = {rd_en & sel_sw, rd_en & sel_key};
    assign ovr_clr = {wr_en & sel_swctrl & ~wdata[OVERRUN_BIT],
                      wr_en & sel_kctrl  & ~wdata[OVERRUN_BIT]};

    // A change wins over a same-edge read or clear; a same-edge read consumes the old data, so no overrun.
    assign ready_d   = any_chg | (ready_q & ~data_rd);
    assign overrun_d = (any_chg & ready_q & ~data_rd) | (overrun_q & ~ovr_clr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q   <= '0;
            overrun_q <= '0;
        end else begin
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel_key)    rdata = DBITS'(key_db);
        if (sel_sw)     rdata = DBITS'(sw_db);
        if (sel_kctrl)  rdata = DBITS'(ctrl_word(ready_q[0], overrun_q[0]));
        if (sel_swctrl) rdata = DBITS'(ctrl_word(ready_q[1], overrun_q[1]));
    end

    logic unused_wdata;
    assign unused_wdata = ^{wdata[DBITS-1:OVERRUN_BIT+1], wdata[OVERRUN_BIT-1:0]};

endmodule
